// File: rtl/h264recon_store.sv
// Reconstruction sink: reorders 4x4 blocks into raster order in a ping-pong MB buffer
// and drains each completed macroblock over a valid/ready word stream.
module h264recon_store #(
   parameter int CHROMA_EN = 1
) (
   input  logic        CLK2,
   input  logic        RESET,
   input  logic        NEWSLICE,
   input  logic        STROBEI,
   input  logic        CSTROBEI,
   input  logic [31:0] DATAI,
   output logic        VALIDO,
   input  logic        READYI,
   output logic [31:0] DATAO,
   output logic        LASTO,
   output logic        ERRO,
   output logic [3:0]  buf_state
);
   typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} buf_t;
   localparam logic [6:0] NWORDS = (CHROMA_EN != 0) ? 7'd96 : 7'd64;
   localparam bit HAS_CHROMA = (CHROMA_EN != 0);

   buf_t        st [2];
   logic [31:0] mem [256];
   logic        wbuf, rbuf;
   logic [1:0]  k;
   logic [4:0]  lumablk;
   logic [3:0]  chromablk;
   logic        cur_chroma, discard;
   logic [6:0]  raddr;

   logic       is_chroma, adv_k, blk_ok, wr, ovf, err_set, complete;
   logic [6:0] waddr;
   logic       cur_done, adv, sel, avail;
   logic [6:0] faddr;

   assign buf_state = {st[1], st[0]};

   // Valid/ready: a word transfers on every CLK2 edge where VALIDO & READYI are both high;
   // while VALIDO is high and READYI low, DATAO and LASTO hold their values.
   always_comb begin
      is_chroma = CSTROBEI;
      adv_k     = 1'b0;
      blk_ok    = 1'b0;
      wr        = 1'b0;
      ovf       = 1'b0;
      err_set   = 1'b0;
      complete  = 1'b0;
      waddr = is_chroma ? {2'b10, chromablk[2], chromablk[1], k, chromablk[0]}
                        : {1'b0, lumablk[3], lumablk[1], k, lumablk[2], lumablk[0]};
      if (!NEWSLICE && (STROBEI || CSTROBEI)) begin
         if (STROBEI && CSTROBEI) err_set = 1'b1;
         else if (CSTROBEI && !HAS_CHROMA) err_set = 1'b1;
         else if (k != 2'd0 && is_chroma != cur_chroma) err_set = 1'b1;
         else begin
            adv_k  = 1'b1;
            blk_ok = is_chroma ? (chromablk < 4'd8) : (lumablk < 5'd16);
            if (!blk_ok) err_set = 1'b1;
            else if (discard || !(st[wbuf] == FREE || st[wbuf] == FILLING)) begin
               ovf     = 1'b1;
               err_set = 1'b1;
            end else wr = 1'b1;
            if (blk_ok && k == 2'd3)
               complete = is_chroma ? (chromablk == 4'd7 && lumablk == 5'd16)
                                    : (lumablk == 5'd15 && (!HAS_CHROMA || chromablk == 4'd8));
         end
      end
   end

   // The word source switches to the other buffer in the same cycle LASTO is taken.
   always_comb begin
      cur_done = VALIDO & READYI & LASTO;
      adv      = ~VALIDO | READYI;
      sel      = cur_done ? ~rbuf : rbuf;
      avail    = 1'b0;
      faddr    = 7'd0;
      if (st[sel] == FULL) avail = 1'b1;
      else if (!cur_done && st[sel] == DRAINING && raddr != NWORDS) begin
         avail = 1'b1;
         faddr = raddr;
      end
   end

   always_ff @(posedge CLK2) begin
      if (wr) mem[{wbuf, waddr}] <= DATAI;
   end

   always_ff @(posedge CLK2 or posedge RESET) begin
      if (RESET) begin
         st[0]      <= FREE;
         st[1]      <= FREE;
         wbuf       <= 1'b0;
         rbuf       <= 1'b0;
         k          <= 2'd0;
         lumablk    <= 5'd0;
         chromablk  <= 4'd0;
         cur_chroma <= 1'b0;
         discard    <= 1'b0;
         raddr      <= 7'd0;
         VALIDO     <= 1'b0;
         LASTO      <= 1'b0;
         ERRO       <= 1'b0;
         DATAO      <= 32'd0;
      end else begin
         if (err_set) ERRO <= 1'b1;
         if (NEWSLICE) begin
            k         <= 2'd0;
            lumablk   <= 5'd0;
            chromablk <= 4'd0;
            discard   <= 1'b0;
            if (st[wbuf] == FILLING) st[wbuf] <= FREE;
         end else begin
            if (ovf) discard <= 1'b1;
            if (wr && st[wbuf] == FREE) st[wbuf] <= FILLING;
            if (adv_k) begin
               k <= k + 2'd1;
               if (k == 2'd0) cur_chroma <= is_chroma;
               if (k == 2'd3 && blk_ok) begin
                  if (is_chroma) chromablk <= chromablk + 4'd1;
                  else           lumablk   <= lumablk + 5'd1;
               end
            end
            // An MB that lost words to overflow still closes here, it just never becomes FULL.
            if (complete) begin
               k         <= 2'd0;
               lumablk   <= 5'd0;
               chromablk <= 4'd0;
               discard   <= 1'b0;
               if (wr) begin
                  st[wbuf] <= FULL;
                  wbuf     <= ~wbuf;
               end
            end
         end
         if (cur_done) begin
            st[rbuf] <= FREE;
            rbuf     <= ~rbuf;
         end
         if (adv) begin
            if (avail) begin
               VALIDO <= 1'b1;
               DATAO  <= mem[{sel, faddr}];
               LASTO  <= (faddr == NWORDS - 7'd1);
               raddr  <= faddr + 7'd1;
               if (st[sel] == FULL) st[sel] <= DRAINING;
            end else begin
               VALIDO <= 1'b0;
               LASTO  <= 1'b0;
            end
         end
      end
   end
endmodule
